// File: rtl/array_snapshot_serializer.sv
// Snapshots a lane array and a packed 3-D array on request and streams them
// as a 5-byte frame (header, lanes, three packed bytes) over valid/ready.
//
// state | meaning
// IDLE  | no frame held, waiting for cap_req
// SEND  | snapshot held, presenting byte idx (0..4) until accepted
module array_snapshot_serializer #(
   parameter int         NLANE   = 4,
   parameter int         LANEW   = 2,
   parameter logic [3:0] HDR_TAG = 4'hA
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cap_req,
   input  logic [LANEW-1:0]       reg1 [NLANE],
   input  logic [1:0][3:0][2:0]   reg4,
   output logic                   cap_busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_data,
   output logic                   out_last,
   output logic                   frame_done,
   output logic [7:0]             drop_cnt
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                   state, state_nxt;
   logic [2:0]               idx, idx_nxt;
   logic [3:0]               seq;
   logic [NLANE*LANEW-1:0]   lane_flat;
   logic [NLANE*LANEW-1:0]   snap_lane;
   logic [23:0]              snap_flat;
   logic                     last_xfer;
   logic                     capture;
   logic                     drop;

   // reg1[0] lands in the least significant bits of the lane byte
   always_comb begin
      lane_flat = '0;
      for (int i = 0; i < NLANE; i++) begin
         lane_flat[i*LANEW +: LANEW] = reg1[i];
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      cap_busy   = 1'b0;
      out_valid  = 1'b0;
      out_data   = 8'h00;
      out_last   = 1'b0;
      frame_done = 1'b0;
      last_xfer  = 1'b0;
      capture    = 1'b0;
      drop       = 1'b0;
      case (state)
         IDLE: begin
            if (cap_req) begin
               capture   = 1'b1;
               state_nxt = SEND;
               idx_nxt   = 3'd0;
            end
         end
         SEND: begin
            cap_busy   = 1'b1;
            out_valid  = 1'b1;
            out_last   = (idx == 3'd4);
            last_xfer  = out_ready && (idx == 3'd4);
            frame_done = last_xfer;
            case (idx)
               3'd0:    out_data = {HDR_TAG, seq};
               3'd1:    out_data = snap_lane[7:0];
               3'd2:    out_data = snap_flat[7:0];
               3'd3:    out_data = snap_flat[15:8];
               default: out_data = snap_flat[23:16];
            endcase
            if (last_xfer) begin
               idx_nxt = 3'd0;
               if (cap_req) begin
                  capture = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (out_ready) begin
               idx_nxt = idx + 3'd1;
            end
            // a request is only honoured on the closing handshake
            drop = cap_req && !last_xfer;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= 3'd0;
         seq       <= 4'd0;
         snap_lane <= '0;
         snap_flat <= 24'h0;
         drop_cnt  <= 8'h00;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (last_xfer) begin
            seq <= seq + 4'd1;
         end
         if (capture) begin
            snap_lane <= lane_flat;
            snap_flat <= reg4;
         end
         if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_array_snapshot_serializer.sv
// Directed bench for array_snapshot_serializer: frame contents, backpressure,
// input freeze, drop counting/saturation, back-to-back seq wrap, mid-frame reset.
module tb_array_snapshot_serializer;

   logic                 clk;
   logic                 rst_n;
   logic                 cap_req;
   logic [1:0]           reg1 [4];
   logic [1:0][3:0][2:0] reg4;
   logic                 cap_busy;
   logic                 out_valid;
   logic                 out_ready;
   logic [7:0]           out_data;
   logic                 out_last;
   logic                 frame_done;
   logic [7:0]           drop_cnt;

   int errors = 0;
   int checks = 0;

   array_snapshot_serializer #(.NLANE(4), .LANEW(2), .HDR_TAG(4'hA)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cap_req    (cap_req),
      .reg1       (reg1),
      .reg4       (reg4),
      .cap_busy   (cap_busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .frame_done (frame_done),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_nominal();
      reg1[0] = 2'd1;
      reg1[1] = 2'd2;
      reg1[2] = 2'd3;
      reg1[3] = 2'd0;
      reg4    = 24'hC0FFEE;
   endtask

   task automatic scramble();
      for (int i = 0; i < 4; i++) reg1[i] = 2'($urandom);
      reg4 = 24'($urandom);
   endtask

   task automatic capture();
      @(negedge clk);
      set_nominal();
      cap_req   = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("idle_before_cap", out_valid, 1'b0);
   endtask

   // Walks one frame starting at the negedge after its capture edge.
   // Inputs are scrambled except on a chained capture cycle.
   task automatic run_frame(input logic [7:0] hdr, input bit bp, input int drops, input bit chain);
      logic [7:0] expb [5];
      int   k    = 0;
      int   cyc  = 0;
      int   left = drops;
      logic rdy;
      expb[0] = hdr;
      expb[1] = 8'h39;
      expb[2] = 8'hEE;
      expb[3] = 8'hFF;
      expb[4] = 8'hC0;
      while (k < 5 && cyc < 60) begin
         @(negedge clk);
         rdy       = bp ? (cyc % 3 == 0) : 1'b1;
         out_ready = rdy;
         cap_req   = 1'b0;
         if (chain && k == 4 && rdy) begin
            set_nominal();
            cap_req = 1'b1;
         end else begin
            scramble();
            if (!rdy && left > 0) begin
               cap_req = 1'b1;
               left--;
            end
         end
         #1;
         chk("valid", out_valid, 1'b1);
         chk("busy", cap_busy, 1'b1);
         chk("data", out_data, expb[k]);
         chk("last", out_last, k == 4);
         chk("done", frame_done, (k == 4) && rdy);
         if (rdy) k++;
         cyc++;
      end
      chk("frame_len", k, 5);
   endtask

   initial begin
      rst_n     = 1'b0;
      cap_req   = 1'b0;
      out_ready = 1'b0;
      set_nominal();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", cap_busy, 1'b0);
      chk("rst_data", out_data, 8'h00);
      chk("rst_drop", drop_cnt, 8'h00);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         chk("idle_valid", out_valid, 1'b0);
         chk("idle_busy", cap_busy, 1'b0);
         chk("idle_drop", drop_cnt, 8'h00);
      end

      // basic frame
      capture();
      run_frame(8'hA0, 1'b0, 0, 1'b0);
      @(negedge clk);
      cap_req = 1'b0;
      #1;
      chk("post_basic_valid", out_valid, 1'b0);

      // backpressure with frozen snapshot
      capture();
      run_frame(8'hA1, 1'b1, 0, 1'b0);

      // three drops during a stalled frame
      capture();
      run_frame(8'hA2, 1'b1, 3, 1'b0);
      @(negedge clk);
      cap_req = 1'b0;
      #1;
      chk("drop3_valid", out_valid, 1'b0);
      chk("drop3_cnt", drop_cnt, 8'd3);

      // 300 more drops saturate the counter
      capture();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         out_ready = 1'b0;
         cap_req   = 1'b1;
      end
      @(negedge clk);
      cap_req = 1'b0;
      #1;
      chk("drop_sat", drop_cnt, 8'hFF);
      chk("sat_hdr", out_data, 8'hA3);
      run_frame(8'hA3, 1'b0, 0, 1'b0);

      // reset in the middle of a frame
      capture();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         cap_req   = 1'b0;
         out_ready = 1'b1;
         #1;
         chk("mid_data", out_data, (k == 0) ? 8'hA4 : (k == 1) ? 8'h39 : 8'hEE);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_busy", cap_busy, 1'b0);
      chk("mid_rst_data", out_data, 8'h00);
      chk("mid_rst_last", out_last, 1'b0);
      chk("mid_rst_drop", drop_cnt, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // 17 back-to-back frames, header wraps AF -> A0
      capture();
      for (int f = 0; f < 17; f++) begin
         run_frame({4'hA, 4'(f)}, 1'b0, 0, f < 16);
      end
      @(negedge clk);
      cap_req = 1'b0;
      #1;
      chk("b2b_end_valid", out_valid, 1'b0);
      chk("b2b_drop", drop_cnt, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
